// File: rtl/pc_ir_unit_if.sv
// Opcode type for the VeriRISC fetch datapath and the strobe/status bundle between controller and PC/IR unit.
// The master side is the controller (drives strobes and read data); the slave side is pc_ir_unit.
package pc_ir_pkg;
  localparam int OPWIDTH = 3;

  typedef enum logic [OPWIDTH-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;
endpackage

interface pc_ir_unit_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic                inc_pc;
  logic                load_pc;
  logic                load_ir;
  logic                halt;
  logic                resume;
  logic [DWIDTH-1:0]   mem_rdata;
  pc_ir_pkg::opcode_t  opcode;
  logic [AWIDTH-1:0]   ir_addr;
  logic [AWIDTH-1:0]   pc;
  logic [AWIDTH-1:0]   mem_addr;
  logic                fetch;
  logic [2:0]          phase;
  logic                halted;

  modport master (
    output inc_pc, load_pc, load_ir, halt, resume, mem_rdata,
    input  opcode, ir_addr, pc, mem_addr, fetch, phase, halted
  );

  modport slave (
    input  inc_pc, load_pc, load_ir, halt, resume, mem_rdata,
    output opcode, ir_addr, pc, mem_addr, fetch, phase, halted
  );
endinterface

// File: rtl/pc_ir_unit.sv
// VeriRISC fetch datapath: PC, IR, memory address mux, 8-phase counter and sticky halt/resume.
// Strobes act at the next rising edge, mem_addr is combinational; no backpressure, strobes are simply ignored while halted.
module pc_ir_unit #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  pc_ir_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT      = 2'd1,
    ST_HALT_PEND = 2'd2
  } run_state_t;

  run_state_t        state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [2:0]        phase_q, phase_d;

  logic              halted;
  logic              last_phase;
  logic              fetch;
  logic [AWIDTH-1:0] ir_addr;

  assign halted     = (state_q != ST_RUN);
  assign last_phase = (phase_q == 3'd7);
  assign fetch      = ~phase_q[2];
  assign ir_addr    = ir_q[AWIDTH-1:0];

  // Halt state machine. A resume pulse only arms release; the actual release
  // waits for the phase-7 edge so execution restarts at INST_ADDR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.halt) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (bus.resume && !bus.halt) state_d = ST_HALT_PEND;
      end
      ST_HALT_PEND: begin
        if (last_phase) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Datapath; strobes seen on the halting edge still take effect.
  always_comb begin
    phase_d = phase_q + 3'd1;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (!halted) begin
      if (bus.load_pc) begin
        pc_d = ir_addr;
      end else if (bus.inc_pc) begin
        pc_d = pc_q + AWIDTH'(1);
      end
      if (bus.load_ir) begin
        ir_d = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      ir_q    <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      phase_q <= phase_d;
    end
  end

  assign bus.opcode   = pc_ir_pkg::opcode_t'(ir_q[DWIDTH-1:AWIDTH]);
  assign bus.ir_addr  = ir_addr;
  assign bus.pc       = pc_q;
  assign bus.mem_addr = fetch ? pc_q : ir_addr;
  assign bus.fetch    = fetch;
  assign bus.phase    = phase_q;
  assign bus.halted   = halted;

endmodule
